// File: rtl/countdown_timer_bcd_pkg.sv
// countdown_timer_bcd_pkg: state encodings and BCD helpers shared by the countdown timer.
package timer_pkg;
    typedef enum logic [1:0] {
        ST_RUNNING  = 2'b00,
        ST_STOPPED  = 2'b01,
        ST_FINISHED = 2'b11
    } state_t;

    localparam int MAX_DIGITS = 8;

    function automatic logic [3:0] digit_limit(input int idx);
        return idx[0] ? 4'd5 : 4'd9;
    endfunction

    // Borrow ripples upward; a digit at 0 reloads its own limit and passes the borrow on.
    function automatic logic [31:0] bcd_dec_1s(input logic [31:0] vec, input int numDigits);
        logic [31:0] res;
        logic borrow;
        res = vec;
        borrow = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++)
            if (borrow && i < numDigits) begin
                if (vec[4*i +: 4] == 4'd0) res[4*i +: 4] = digit_limit(i);
                else begin
                    res[4*i +: 4] = vec[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        return res;
    endfunction

    function automatic logic bcd_is_zero(input logic [31:0] vec);
        return vec == 32'd0;
    endfunction
endpackage

// File: rtl/countdown_timer_bcd_if.sv
// countdown_timer_bcd_if: raw push-buttons in, time/state/cursor display signals out.
interface countdown_timer_bcd_if #(parameter int NUM_DIGITS = 4);
    logic                          btn_up;
    logic                          btn_down;
    logic                          btn_left;
    logic                          btn_right;
    logic                          btn_action;
    logic [4*NUM_DIGITS-1:0]       time_bcd;
    logic [1:0]                    state;
    logic [$clog2(NUM_DIGITS)-1:0] cursor;
    logic                          cursor_valid;
    logic                          done_pulse;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_action,
        input  time_bcd, state, cursor, cursor_valid, done_pulse
    );
    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_action,
        output time_bcd, state, cursor, cursor_valid, done_pulse
    );
endinterface

// File: rtl/countdown_timer_bcd_btn_sync_edge.sv
// btn_sync_edge: synchronises an asynchronous level and emits a one-cycle pulse on its rising edge.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] syncQ;
    logic                   prevQ;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            syncQ <= '0;
            prevQ <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], din};
            prevQ <= syncQ[SYNC_STAGES-1];
        end

    assign pulse = syncQ[SYNC_STAGES-1] & ~prevQ;
endmodule

// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd: editable BCD MM:SS countdown with 1 s prescaler, pause/resume and preset restore.
module countdown_timer_bcd
    import timer_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int NUM_DIGITS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    countdown_timer_bcd_if.slave  bus
);
    localparam int TW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(TICK_DIV);

    logic upP, downP, leftP, rightP, actionP;
    state_t         stateQ, stateD;
    logic [TW-1:0]  timeQ, timeD, presetQ, presetD, timeDec;
    logic [CW-1:0]  cursorQ, cursorD;
    logic [PW-1:0]  preQ, preD;
    logic           doneQ, doneD;
    logic [3:0]     curDigit, curLimit;
    logic           editUp, editDown, moveLeft, moveRight, tick;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uUp     (.clk(clk), .rst_n(rst_n), .din(bus.btn_up),     .pulse(upP));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uDown   (.clk(clk), .rst_n(rst_n), .din(bus.btn_down),   .pulse(downP));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uLeft   (.clk(clk), .rst_n(rst_n), .din(bus.btn_left),   .pulse(leftP));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uRight  (.clk(clk), .rst_n(rst_n), .din(bus.btn_right),  .pulse(rightP));
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uAction (.clk(clk), .rst_n(rst_n), .din(bus.btn_action), .pulse(actionP));

    // Opposing buttons pressed together cancel each other.
    assign editUp    = upP & ~downP;
    assign editDown  = downP & ~upP;
    assign moveLeft  = leftP & ~rightP;
    assign moveRight = rightP & ~leftP;
    assign tick      = preQ == PW'(TICK_DIV - 1);
    assign curDigit  = timeQ[4*cursorQ +: 4];
    assign curLimit  = digit_limit(int'(cursorQ));
    assign timeDec   = TW'(bcd_dec_1s(32'(timeQ), NUM_DIGITS));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stateQ  <= ST_STOPPED;
            timeQ   <= '0;
            presetQ <= '0;
            cursorQ <= '0;
            preQ    <= '0;
            doneQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            timeQ   <= timeD;
            presetQ <= presetD;
            cursorQ <= cursorD;
            preQ    <= preD;
            doneQ   <= doneD;
        end

    always_comb begin
        stateD  = stateQ;
        timeD   = timeQ;
        presetD = presetQ;
        cursorD = cursorQ;
        preD    = preQ;
        doneD   = 1'b0;
        case (stateQ)
            ST_STOPPED: begin
                if (actionP) begin
                    if (!bcd_is_zero(32'(timeQ))) begin
                        presetD = timeQ;
                        preD    = '0;
                        stateD  = ST_RUNNING;
                    end
                end else if (editUp || editDown) begin
                    timeD[4*cursorQ +: 4] = editUp ? (curDigit == curLimit ? 4'd0 : curDigit + 4'd1)
                                                   : (curDigit == 4'd0 ? curLimit : curDigit - 4'd1);
                end else if (moveLeft || moveRight) begin
                    cursorD = moveLeft ? (cursorQ == CW'(NUM_DIGITS - 1) ? '0 : cursorQ + 1'b1)
                                       : (cursorQ == '0 ? CW'(NUM_DIGITS - 1) : cursorQ - 1'b1);
                end
            end
            ST_RUNNING: begin
                if (actionP) begin
                    stateD  = ST_STOPPED;
                    cursorD = '0;
                    preD    = '0;
                end else if (tick) begin
                    preD  = '0;
                    timeD = timeDec;
                    if (bcd_is_zero(32'(timeDec))) begin
                        stateD = ST_FINISHED;
                        doneD  = 1'b1;
                    end
                end else begin
                    preD = preQ + 1'b1;
                end
            end
            default: begin
                if (actionP) begin
                    stateD  = ST_STOPPED;
                    timeD   = presetQ;
                    cursorD = '0;
                end
            end
        endcase
    end

    assign bus.time_bcd     = timeQ;
    assign bus.state        = stateQ;
    assign bus.cursor       = cursorQ;
    assign bus.cursor_valid = stateQ == ST_STOPPED;
    assign bus.done_pulse   = doneQ;
endmodule
